// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a combinational 32x32 signed multiplier.
// Holds operands for MUL_CYCLES settle cycles, captures the product into HI/LO,
// and handles the mthi/mtlo write path.
module mul_seq_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_product,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // DONE behaves like IDLE for start and direct writes, so back-to-back
  // multiplies need no bubble and a DONE-cycle write lands after the capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        if (hi_wr) hi_d = wr_data;
        if (lo_wr) lo_d = wr_data;
        if (start) begin
          state_d = WAIT;
          cnt_d   = 4'(MUL_CYCLES);
          x_d     = op_a;
          y_d     = op_b;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = mul_product[63:32];
          lo_d    = mul_product[31:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == WAIT);
  assign done   = (state_q == DONE);
  assign mul_x  = x_q;
  assign mul_y  = y_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural signed multiplier on
// mul_x/mul_y; inputs driven and outputs sampled on the falling edge.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [31:0] mul_x, mul_y;
  logic [63:0] mul_product;
  logic        hi_wr, lo_wr;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  logic signed [63:0] ax, ay;
  assign ax = {{32{mul_x[31]}}, mul_x};
  assign ay = {{32{mul_y[31]}}, mul_y};
  assign mul_product = ax * ay;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_x(mul_x), .mul_y(mul_y), .mul_product(mul_product),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  // Waits (falling edges) while busy; returns cycles spent, bounded.
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
    #12;
    checks++;
    if ({busy, done, hi_out, lo_out, mul_x, mul_y} !== 130'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h x=%h y=%h, want all 0",
               busy, done, hi_out, lo_out, mul_x, mul_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cnt;
    op_a = 32'd7; op_b = 32'hFFFFFFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || mul_x !== 32'd7 || mul_y !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL basic_accept: busy=%b done=%b x=%h y=%h, want 1 0 7 fffffffd",
               busy, done, mul_x, mul_y);
    end
    wait_busy(cnt);
    checks++;
    if (cnt !== 4) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d cycles, want 4", cnt);
    end
    checks++;
    if (done !== 1'b1 || hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL basic_result: done=%b hi=%h lo=%h, want 1 ffffffff ffffffeb",
               done, hi_out, lo_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_stable;
    int cnt;
    bit moved;
    op_a = 32'h80000000; op_b = 32'h80000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    moved = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      op_a = 32'h1111_0000 + cnt; op_b = 32'h2222_0000 + cnt;
      if (mul_x !== 32'h80000000 || mul_y !== 32'h80000000) moved = 1'b1;
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (moved || mul_x !== 32'h80000000 || mul_y !== 32'h80000000) begin
      errors++;
      $display("FAIL stable_operands: x=%h y=%h moved=%b, want 80000000 held", mul_x, mul_y, moved);
    end
    checks++;
    if (done !== 1'b1 || hi_out !== 32'h40000000 || lo_out !== 32'h00000000) begin
      errors++;
      $display("FAIL stable_result: done=%b hi=%h lo=%h, want 1 40000000 00000000",
               done, hi_out, lo_out);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cnt;
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    wait_busy(cnt);
    checks++;
    if (done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd6 || mul_x !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first: done=%b hi=%h lo=%h x=%h, want 1 0 6 2", done, hi_out, lo_out, mul_x);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || mul_x !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL b2b_no_gap: busy=%b done=%b x=%h, want 1 0 ffffffff", busy, done, mul_x);
    end
    wait_busy(cnt);
    checks++;
    if (cnt !== 4 || done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d done=%b hi=%h lo=%h, want 4 1 0 1", cnt, done, hi_out, lo_out);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored;
    int cnt;
    op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; hi_wr = 1'b1; wr_data = 32'hDEADBEEF; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    checks++;
    if (busy !== 1'b1 || mul_x !== 32'd5 || hi_out === 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ign_midwait: busy=%b x=%h hi=%h, want 1 5 not deadbeef", busy, mul_x, hi_out);
    end
    wait_busy(cnt);
    checks++;
    if (done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd30) begin
      errors++;
      $display("FAIL ign_result: done=%b hi=%h lo=%h, want 1 0 1e", done, hi_out, lo_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ign_not_queued: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_done_write;
    int cnt;
    op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(cnt);
    lo_wr = 1'b1; wr_data = 32'h0000AAAA;
    @(negedge clk);
    lo_wr = 1'b0;
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'h0000AAAA) begin
      errors++;
      $display("FAIL done_write: hi=%h lo=%h, want 0 0000aaaa", hi_out, lo_out);
    end
  endtask

  task automatic test_async_reset;
    hi_wr = 1'b1; wr_data = 32'h1;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b1; wr_data = 32'h2;
    @(negedge clk);
    lo_wr = 1'b0;
    checks++;
    if (hi_out !== 32'h1 || lo_out !== 32'h2) begin
      errors++;
      $display("FAIL areset_pre: hi=%h lo=%h, want 1 2", hi_out, lo_out);
    end
    op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi_out, lo_out, mul_x, mul_y} !== 130'd0) begin
      errors++;
      $display("FAIL areset_now: busy=%b done=%b hi=%h lo=%h x=%h y=%h, want all 0",
               busy, done, hi_out, lo_out, mul_x, mul_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
        errors++;
        $display("FAIL areset_after: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0",
                 busy, done, hi_out, lo_out);
      end
    end
  endtask

  task automatic test_direct_write;
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h12345678;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    checks++;
    if (hi_out !== 32'h12345678 || lo_out !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL direct_write: hi=%h lo=%h busy=%b done=%b, want 12345678 12345678 0 0",
               hi_out, lo_out, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stable();
    test_back_to_back();
    test_ignored();
    test_done_write();
    test_async_reset();
    test_direct_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
